// File: rtl/key_pkg.sv
// Shared types and constants for the key debouncer.
// Optional event outputs: KEY_DEBOUNCE_EVENT_EN.
package key_pkg;

  localparam int KEY_NUM = 10;

  typedef enum logic [1:0] {
    REL,
    PRESS_WAIT,
    PRS,
    REL_WAIT
  } deb_state_t;

  function automatic int cnt_width(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchronizer, debounce FSM and window counter.
// Optional press/release pulses: KEY_DEBOUNCE_EVENT_EN.
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw_n,
`ifdef KEY_DEBOUNCE_EVENT_EN
  output logic key_press,
  output logic key_release,
`endif
  output logic s_n
);

  localparam int CNT_W = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  deb_state_t       state;
  deb_state_t       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             s_n_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= REL;
      cnt   <= '0;
      s_n   <= 1'b1;
    end else begin
      sync1 <= key_raw_n;
      sync2 <= sync1;
      state <= state_n;
      cnt   <= cnt_n;
      s_n   <= s_n_d;
    end
  end

  // Any sample back at the settled level drops the window.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    s_n_d   = s_n;
    unique case (state)
      REL: begin
        if (!sync2) begin
          state_n = PRESS_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (sync2) begin
          state_n = REL;
        end else if (cnt == LAST) begin
          state_n = PRS;
          s_n_d   = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PRS: begin
        if (sync2) begin
          state_n = REL_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      REL_WAIT: begin
        if (!sync2) begin
          state_n = PRS;
        end else if (cnt == LAST) begin
          state_n = REL;
          s_n_d   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = REL;
        s_n_d   = 1'b1;
      end
    endcase
  end

`ifdef KEY_DEBOUNCE_EVENT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= s_n & ~s_n_d;
      key_release <= ~s_n & s_n_d;
    end
  end
`endif

endmodule

// File: rtl/key_debounce.sv
// Debouncer for the keyboard encoder: one cell per key.
// Optional press/release pulses: KEY_DEBOUNCE_EVENT_EN.
module key_debounce #(
  parameter int DEB_CYCLES = 16,
  parameter int KEY_NUM    = key_pkg::KEY_NUM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_raw_n,
`ifdef KEY_DEBOUNCE_EVENT_EN
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
`endif
  output logic [KEY_NUM-1:0] S_n
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce_cell #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .key_raw_n  (key_raw_n[i]),
`ifdef KEY_DEBOUNCE_EVENT_EN
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
`endif
      .s_n        (S_n[i])
    );
  end

endmodule
